mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU from the EX stage and runs a 32-step shift-add multiply or restoring divide under a small FSM. It drives a stall to the hazard logic while busy, so a second MDU op or an MFHI/MFLO cannot proceed until HI/LO are valid. It sits beside the ALU, sequenced by the controller's decoded MDU signals.

## Interface
Parameters:
- none. Width fixed at 32; iteration count fixed at 32.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous reset, no async path.
- start  in  1  EX-stage instruction is an MDU op.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- srca  in  32  rs operand (multiplicand / dividend).
- srcb  in  32  rt operand (multiplier / divisor).
- rd_req  in  1  EX-stage instruction is MFHI or MFLO.
- busy  out  1  FSM not in IDLE.
- stall  out  1  combinational: busy & (start | rd_req).
- done  out  1  one-cycle pulse, high in the cycle HI/LO first show a new result.
- hi  out  32  HI register (product high / remainder).
- lo  out  32  LO register (product low / quotient).

## Operation
- States: IDLE, RUN, SIGN.
- IDLE:
  - start=1 at an edge latches op and operand magnitudes (abs value if signed op, else raw).
  - Records result sign (mult: sa^sb; quotient: sa^sb; remainder: sa).
  - Clears 5-bit count and accumulator; goes to RUN.
- RUN:
  - One iteration per edge.
  - Multiply: 64-bit shift-add, LSB of multiplier first.
  - Divide: restoring; shift remainder left, trial subtract, quotient bit = no borrow.
  - count increments; on count==31 goes to SIGN.
- SIGN:
  - Conditionally two's-complement negates the result halves per recorded signs.
  - Writes hi/lo; goes to IDLE.
- done is a registered pulse asserted in the cycle after the SIGN edge, i.e. the cycle HI/LO hold the new value.
- Divide by zero (srcb==0), any signedness: LO=0xFFFFFFFF, HI=srca (original, unnegated).
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- Signed remainder takes the sign of the dividend; the quotient truncates toward zero.
- start while busy: ignored by the MDU. stall holds the pipeline, so the same instruction re-presents start and is accepted at the first edge in IDLE.
- start and rd_req together in IDLE: no stall; rd_req reads the current (old) hi/lo.
- Reset values: state IDLE, hi=0, lo=0, busy=0, done=0, stall=0.
- Reset mid-RUN/SIGN: the operation is abandoned; HI/LO go to 0, not to a partial result.

## Timing
- Start accepted at edge E0.
- busy=1 from E0 through the SIGN edge, which is E0+33.
- hi/lo valid, done=1, busy=0 in the cycle after E0+33.
- Fixed latency: 34 cycles from acceptance to result, independent of operands and op.
- MFHI issued the cycle after start stalls 33 cycles, then reads the new value.
- Back-to-back MDU ops: the second is accepted at the first edge with busy=0, giving one op per 34 cycles.
- stall has no registered delay; it is valid in the same cycle as start/rd_req.

## Configuration
- MDU_SIGNED_EN defined:
  - MULT and DIV perform signed magnitude conversion and the SIGN-state correction as above.
- MDU_SIGNED_EN undefined:
  - op[0] is ignored; MULT behaves as MULTU and DIV as DIVU.
  - No abs/negate logic is built.
  - The SIGN state remains as a pass-through cycle, so latency stays 34.
  - The signed-overflow rule does not apply.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at E0 -> at E0+34: HI=0xFFFFFFFE, LO=0x00000001, done pulse one cycle, busy low.
- MULT 0xFFFFFFFD (−3) × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Without MDU_SIGNED_EN -> HI=0x00000004, LO=0xFFFFFFF1.
- DIV 0xFFFFFFF9 (−7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=0x00000005.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0, no hang, latency 34.
- Second start plus rd_req held from E0+1 -> stall=1 for cycles E0+1..E0+33, 0 after. Second op accepted at edge E0+34; its result at E0+68.
- reset asserted 10 cycles into RUN -> next cycle busy=0, stall=0, hi=lo=0, no done pulse. A new start then completes normally in 34 cycles.

Source files
------------

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - iterative 32-bit multiply/divide unit with HI/LO registers
//
// Runs MULTU/MULT/DIVU/DIV as a 32-step shift-add multiply or restoring divide.
// Every op takes a fixed 34 cycles: one accept edge, 32 RUN edges and one SIGN edge.
// Optional feature macro: MDU_SIGNED_EN. When it is defined, MULT/DIV apply signed
// magnitude conversion and a sign fix-up. When it is not defined, op[0] is ignored.
//
// Ports:
//   clk     system clock; all state updates on the rising edge
//   reset   synchronous, active-high
//   start   EX-stage instruction is an MDU op
//   op      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   srca    rs operand (multiplicand / dividend)
//   srcb    rt operand (multiplier / divisor)
//   rd_req  EX-stage instruction is MFHI/MFLO
//   busy    FSM not idle
//   stall   busy & (start | rd_req), combinational
//   done    one-cycle pulse in the first cycle HI/LO hold a new result
//   hi, lo  HI (product high / remainder) and LO (product low / quotient)

module mdu_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        rd_req,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  count_q, count_d;
  // Multiply: {partial product high, multiplier shifting out}.
  // Divide: {remainder, dividend shifting out / quotient shifting in}.
  logic [63:0] acc_q, acc_d;
  // Multiplicand (multiply) or divisor (divide), held as a magnitude.
  logic [31:0] opnd_q, opnd_d;
  logic        is_div_q, is_div_d;
  logic        div0_q, div0_d;
  // The original dividend is kept because divide-by-zero reports it unchanged in HI.
  logic [31:0] dvnd_q, dvnd_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic [31:0] mag_a, mag_b;
  logic [63:0] result;
  logic [32:0] mul_sum;
  logic [33:0] div_diff;
  logic        div_ok;

`ifdef MDU_SIGNED_EN
  logic sa, sb;
  // neg_q: sign of product or quotient; neg_rem_q: sign of remainder (follows dividend).
  logic neg_q, neg_d;
  logic neg_rem_q, neg_rem_d;

  assign sa    = op[0] & srca[31];
  assign sb    = op[0] & srcb[31];
  assign mag_a = sa ? (32'd0 - srca) : srca;
  assign mag_b = sb ? (32'd0 - srcb) : srcb;

  always_comb begin
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    if (state_q == S_IDLE && start) begin
      neg_d     = sa ^ sb;
      neg_rem_d = sa;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
    end
  end
`else
  logic unused_op0;
  assign unused_op0 = op[0];
  assign mag_a      = srca;
  assign mag_b      = srcb;
`endif

  // One iteration of each algorithm.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  // Trial subtract of the left-shifted remainder; the MSB is the borrow.
  assign div_diff = {1'b0, acc_q[63:31]} - {2'b00, opnd_q};
  assign div_ok   = ~div_diff[33];

  // Final result with sign correction. A 0x80000000 / -1 result negates to itself,
  // so the signed-overflow case needs no special handling.
  always_comb begin
    result = acc_q;
`ifdef MDU_SIGNED_EN
    if (is_div_q) begin
      if (neg_q)     result[31:0]  = 32'd0 - acc_q[31:0];
      if (neg_rem_q) result[63:32] = 32'd0 - acc_q[63:32];
    end else if (neg_q) begin
      result = 64'd0 - acc_q;
    end
`endif
    if (div0_q) result = {dvnd_q, 32'hFFFF_FFFF};
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;
    dvnd_d   = dvnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d = op[1];
          div0_d   = op[1] & (srcb == 32'd0);
          dvnd_d   = srca;
          acc_d    = {32'd0, (op[1] ? mag_a : mag_b)};
          opnd_d   = op[1] ? mag_b : mag_a;
          count_d  = 5'd0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (is_div_q)
          acc_d = {(div_ok ? div_diff[31:0] : acc_q[62:31]), acc_q[30:0], div_ok};
        else
          acc_d = {mul_sum, acc_q[31:1]};
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) state_d = S_SIGN;
      end
      S_SIGN: begin
        hi_d    = result[63:32];
        lo_d    = result[31:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= 5'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      dvnd_q   <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
      dvnd_q   <= dvnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign stall = busy & (start | rd_req);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - scoreboard testbench for mdu_sequencer

module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srca = 32'd0;
  logic [31:0] srcb = 32'd0;
  logic        rd_req = 1'b0;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  mdu_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .srca   (srca),
    .srcb   (srcb),
    .rd_req (rd_req),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          free_cyc = 0;
  logic [31:0] cur_hi = 32'd0;
  logic [31:0] cur_lo = 32'd0;
  logic        prev_done = 1'b0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural rules.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ua, ub;
    int          ia, ib;
    longint      p;
    bit          sgn;
`ifdef MDU_SIGNED_EN
    sgn = o[0];
`else
    sgn = 1'b0;
`endif
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    if (!o[1]) begin
      if (sgn) begin
        p = longint'(ia) * longint'(ib);
        return p;
      end
      return ua * ub;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      return {32'(ia % ib), 32'(ia / ib)};
    end
    return {a % b, a / b};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: samples at the falling edge, before the stimulus drives anything.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        if (sbq.size() == 0) begin
          cmp("spurious_done", {63'd0, done}, 64'd0);
        end else begin
          e = sbq.pop_front();
          cmp({e.tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
          cmp({e.tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
          cmp({e.tag, "_latency"}, 64'(cyc), 64'(e.due));
          cmp({e.tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
          cur_hi = e.hi;
          cur_lo = e.lo;
        end
        cmp("done_width", {63'd0, prev_done & done}, 64'd0);
      end else begin
        cmp("hilo_hold", {hi, lo}, {cur_hi, cur_lo});
        if (sbq.size() != 0 && cyc > sbq[0].due) begin
          e = sbq.pop_front();
          cmp({e.tag, "_done_timeout"}, {63'd0, done}, 64'd1);
        end
      end
      prev_done = done;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Presents an op and holds start until the model says the unit is idle.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expv, input string tag);
    exp_t e;
    bit   accepted;
    accepted = 1'b0;
    for (int k = 0; k < 40 && !accepted; k++) begin
      step();
      start  = 1'b1;
      op     = o;
      srca   = a;
      srcb   = b;
      rd_req = 1'($urandom_range(0, 1));
      #1;
      cmp({tag, "_stall"}, {63'd0, stall}, {63'd0, (cyc < free_cyc)});
      if (cyc >= free_cyc) begin
        e.hi  = expv[63:32];
        e.lo  = expv[31:0];
        e.due = cyc + 34;
        e.tag = tag;
        sbq.push_back(e);
        free_cyc = cyc + 34;
        accepted = 1'b1;
      end
    end
    if (!accepted) cmp({tag, "_accept_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic gap(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      start  = 1'b0;
      rd_req = 1'($urandom_range(0, 1));
      #1;
      cmp("gap_stall", {63'd0, stall}, {63'd0, (cyc < free_cyc) & rd_req});
    end
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;

    reset  = 1'b1;
    start  = 1'b1;
    rd_req = 1'b1;
    step();
    step();
    cmp("rst_busy",  {63'd0, busy},  64'd0);
    cmp("rst_stall", {63'd0, stall}, 64'd0);
    cmp("rst_done",  {63'd0, done},  64'd0);
    cmp("rst_hilo",  {hi, lo},       64'd0);
    start  = 1'b0;
    rd_req = 1'b0;
    step();
    reset = 1'b0;

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, "multu_max");
    gap(36);
`ifdef MDU_SIGNED_EN
    issue(2'b01, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, "mult_neg3x5");
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_neg7by2");
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, "div_ovf");
    issue(2'b11, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, "div_7byneg2");
`else
    issue(2'b01, 32'hFFFF_FFFD, 32'd5, {32'h0000_0004, 32'hFFFF_FFF1}, "mult_neg3x5");
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, {32'h0000_0001, 32'h7FFF_FFFC}, "div_neg7by2");
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}, "div_ovf");
    issue(2'b11, 32'd7, 32'hFFFF_FFFE, {32'h0000_0007, 32'h0000_0000}, "div_7byneg2");
`endif
    issue(2'b10, 32'd5, 32'd0, {32'h0000_0005, 32'hFFFF_FFFF}, "divu_by0");
    issue(2'b11, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, "div_by0");
    gap(3);

    // Reset ten cycles into RUN abandons the op.
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, model(2'b00, 32'h1234_5678, 32'h9ABC_DEF0), "aborted");
    gap(11);
    reset  = 1'b1;
    start  = 1'b1;
    rd_req = 1'b1;
    sbq.delete();
    cur_hi   = 32'd0;
    cur_lo   = 32'd0;
    free_cyc = 0;
    step();
    cmp("midrun_rst_busy",  {63'd0, busy},  64'd0);
    cmp("midrun_rst_stall", {63'd0, stall}, 64'd0);
    cmp("midrun_rst_done",  {63'd0, done},  64'd0);
    cmp("midrun_rst_hilo",  {hi, lo},       64'd0);
    start  = 1'b0;
    rd_req = 1'b0;
    reset  = 1'b0;
    issue(2'b10, 32'd100, 32'd7, {32'd2, 32'd14}, "after_rst");

    for (int i = 0; i < 50; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      issue(o, a, b, model(o, a, b), $sformatf("rnd%0d", i));
      gap($urandom_range(0, 3));
    end

    for (int k = 0; k < 45 && sbq.size() != 0; k++) gap(1);
    cmp("drain", 64'(sbq.size()), 64'd0);
    gap(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
